// File: rtl/vdo_stream_ctrl.sv
// Video stream gate and CSI-2 TX configurator: qualifies format reports, hands over line/frame config,
// opens the AXI4-Stream path on SOF and closes it at the next frame boundary on format change or loss.
module vdo_stream_ctrl #(
   parameter int          STABLE_CNT  = 3,
   parameter logic [23:0] ARM_TIMEOUT = 24'hFFFFFF,
   parameter logic [11:0] WPL_1080    = 12'd960,
   parameter logic [11:0] LPF_1080    = 12'd1080,
   parameter logic [11:0] WPL_4K      = 12'd1920,
   parameter logic [11:0] LPF_4K      = 12'd2160
) (
   input  logic        aclk,
   input  logic        rst,
   input  logic        fmt_update,
   input  logic [1:0]  frame_format,
   input  logic [47:0] s_axis_tdata,
   input  logic        s_axis_tuser,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [47:0] m_axis_tdata,
   output logic        m_axis_tuser,
   output logic        m_axis_tlast,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        cfg_valid,
   input  logic        cfg_ready,
   output logic [11:0] cfg_wpl,
   output logic [11:0] cfg_lpf,
   output logic [1:0]  cfg_fmt,
   output logic        stream_on,
   output logic [2:0]  ctrl_state,
   output logic [7:0]  drop_cnt
);

   localparam int CW = $clog2(STABLE_CNT + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_QUAL   = 3'd1,
      S_CFG    = 3'd2,
      S_ARM    = 3'd3,
      S_STREAM = 3'd4,
      S_DRAIN  = 3'd5
   } state_t;

   state_t        state;
   logic [1:0]    cand;
   logic [CW-1:0] count;
   logic [23:0]   timer;
   logic          abort_pend;
   logic          drain_pend;

   logic          fmt_diff;
   logic [1:0]    next_fmt;
   logic          gate_open;
   logic          stall;
   logic          sof_acc;

   function automatic logic [11:0] map_wpl(input logic [1:0] f);
      case (f)
         2'b01:        map_wpl = WPL_1080;
         2'b10, 2'b11: map_wpl = WPL_4K;
         default:      map_wpl = 12'd0;
      endcase
   endfunction

   function automatic logic [11:0] map_lpf(input logic [1:0] f);
      case (f)
         2'b01:        map_lpf = LPF_1080;
         2'b10, 2'b11: map_lpf = LPF_4K;
         default:      map_lpf = 12'd0;
      endcase
   endfunction

   assign fmt_diff = fmt_update & (frame_format != cfg_fmt);
   assign next_fmt = fmt_update ? frame_format : cand;

   // In ARM only an SOF beat may pass, and a conflicting report in the same cycle vetoes it.
   always_comb begin
      gate_open = 1'b0;
      case (state)
         S_ARM:    gate_open = s_axis_tvalid & s_axis_tuser & ~fmt_diff;
         S_STREAM: gate_open = 1'b1;
         S_DRAIN:  gate_open = ~s_axis_tuser;
         default:  gate_open = 1'b0;
      endcase
   end

   assign m_axis_tvalid = gate_open & s_axis_tvalid;
   assign s_axis_tready = gate_open ? m_axis_tready : 1'b1;
   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tuser  = s_axis_tuser;
   assign m_axis_tlast  = s_axis_tlast;

   assign stall   = s_axis_tvalid & ~s_axis_tready;
   assign sof_acc = s_axis_tvalid & s_axis_tready & s_axis_tuser;

   assign cfg_valid  = (state == S_CFG);
   assign stream_on  = (state == S_STREAM) || (state == S_DRAIN);
   assign ctrl_state = state;

   always_ff @(posedge aclk) begin
      if (rst) begin
         state      <= S_IDLE;
         cand       <= 2'b00;
         count      <= '0;
         timer      <= 24'd0;
         abort_pend <= 1'b0;
         drain_pend <= 1'b0;
         cfg_fmt    <= 2'b00;
         cfg_wpl    <= 12'd0;
         cfg_lpf    <= 12'd0;
         drop_cnt   <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (fmt_update && frame_format != 2'b00) begin
                  cand  <= frame_format;
                  count <= CW'(1);
                  state <= S_QUAL;
               end
            end
            S_QUAL: begin
               if (fmt_update) begin
                  if (frame_format == 2'b00) begin
                     state <= S_IDLE;
                  end else if (frame_format == cand) begin
                     if (count != CW'(STABLE_CNT)) count <= count + CW'(1);
                  end else begin
                     cand  <= frame_format;
                     count <= CW'(1);
                  end
               end else if (count == CW'(STABLE_CNT)) begin
                  state      <= S_CFG;
                  cfg_fmt    <= cand;
                  cfg_wpl    <= map_wpl(cand);
                  cfg_lpf    <= map_lpf(cand);
                  abort_pend <= 1'b0;
               end
            end
            S_CFG: begin
               // The offered config is never withdrawn; a conflicting report only redirects after acceptance.
               if (fmt_update) begin
                  cand       <= frame_format;
                  abort_pend <= fmt_diff;
               end
               if (cfg_ready) begin
                  if (fmt_update ? fmt_diff : abort_pend) begin
                     count <= CW'(1);
                     state <= (next_fmt == 2'b00) ? S_IDLE : S_QUAL;
                  end else begin
                     timer <= 24'd0;
                     state <= S_ARM;
                  end
               end
            end
            S_ARM: begin
               if (fmt_diff) begin
                  cand  <= frame_format;
                  count <= CW'(1);
                  state <= (frame_format == 2'b00) ? S_IDLE : S_QUAL;
               end else if (sof_acc) begin
                  state <= S_STREAM;
               end else if (timer == ARM_TIMEOUT) begin
                  state <= S_IDLE;
               end else begin
                  timer <= timer + 24'd1;
               end
            end
            S_STREAM: begin
               // Hold off the switch while a beat is stalled so the gate never changes under it.
               if (fmt_update) cand <= frame_format;
               if ((fmt_diff || drain_pend) && !stall) begin
                  state      <= S_DRAIN;
                  drain_pend <= 1'b0;
                  if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
               end else if (fmt_diff) begin
                  drain_pend <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (fmt_update) cand <= frame_format;
               if (s_axis_tvalid && s_axis_tuser) begin
                  count <= CW'(1);
                  state <= (next_fmt == 2'b00) ? S_IDLE : S_QUAL;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
